// File: rtl/id_ex_stage.sv
// id_ex_stage: single-entry ID/EX pipeline register with RV32 ALU decode.
//
// Ports:
//   clk_i, rst_n              clock, async active-low reset
//   in_valid / in_ready       upstream handshake
//   instr_i                   RV32 instruction word
//   rs1_data_i, rs2_data_i    register-file read data for instr_i
//   flush_i                   drop held instruction and this cycle's input
//   out_ready / out_valid     downstream handshake
//   rs1_data, mux_o           ALU operands (rs1, rs2-or-immediate)
//   AluControl                ALU op code
//   rd_addr, reg_write        destination register and write enable
//   illegal                   undecodable-instruction flag
//   alu_result_i              forwarded ALU result (ID_EX_FORWARD_EN only)
//
// Optional feature macro: ID_EX_FORWARD_EN adds EX->ID operand forwarding.

module id_ex_stage #(
    parameter int         DW          = 32,
    parameter logic [2:0] BUBBLE_CTRL = 3'b000
) (
    input  logic          clk_i,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   instr_i,
    input  logic [DW-1:0] rs1_data_i,
    input  logic [DW-1:0] rs2_data_i,
    input  logic          flush_i,
`ifdef ID_EX_FORWARD_EN
    input  logic [DW-1:0] alu_result_i,
`endif
    input  logic          out_ready,
    output logic          out_valid,
    output logic [DW-1:0] rs1_data,
    output logic [DW-1:0] mux_o,
    output logic [2:0]    AluControl,
    output logic [4:0]    rd_addr,
    output logic          reg_write,
    output logic          illegal
);

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_MUL   = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_XOR   = 3'b100;
    localparam logic [2:0] ALU_SL    = 3'b101;
    localparam logic [2:0] ALU_SR    = 3'b110;
    localparam logic [2:0] ALU_WRONG = 3'b111;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    typedef enum logic [1:0] {
        SRC_RS2,
        SRC_SIMM,
        SRC_SHAMT
    } src_e;

    // Registered state
    logic          r_valid;
    logic [2:0]    r_ctrl;
    logic [DW-1:0] r_rs1;
    logic [DW-1:0] r_mux;
    logic [4:0]    r_rd;
    logic          r_we;
    logic          r_ill;

    // Decode fields
    logic [6:0]    w_opcode;
    logic [2:0]    w_f3;
    logic [6:0]    w_f7;
    logic          w_is_r;

    // Decode results
    logic [2:0]    w_ctrl;
    logic          w_ill;
    src_e          w_src;

    // Operand path
    logic [DW-1:0] w_op_a;
    logic [DW-1:0] w_rs2;
    logic [DW-1:0] w_simm;
    logic [DW-1:0] w_shamt;
    logic [DW-1:0] w_op_b;

    // Handshake
    logic          w_in_ready;
    logic          w_xfer;
    logic          w_drain;

    assign w_opcode = instr_i[6:0];
    assign w_f3     = instr_i[14:12];
    assign w_f7     = instr_i[31:25];
    assign w_is_r   = (w_opcode == OP_R);

    assign w_in_ready = !r_valid || out_ready;
    assign w_xfer     = in_valid && w_in_ready && !flush_i;
    assign w_drain    = r_valid && out_ready;

    always_comb begin
        w_ctrl = ALU_WRONG;
        w_ill  = 1'b1;
        w_src  = SRC_RS2;
        unique case (w_opcode)
            OP_R: begin
                unique case ({w_f7, w_f3})
                    {F7_BASE, 3'b000}: begin
                        w_ctrl = ALU_ADD;
                        w_ill  = 1'b0;
                    end
                    {F7_ALT, 3'b000}: begin
                        w_ctrl = ALU_SUB;
                        w_ill  = 1'b0;
                    end
                    {F7_MUL, 3'b000}: begin
                        w_ctrl = ALU_MUL;
                        w_ill  = 1'b0;
                    end
                    {F7_BASE, 3'b111}: begin
                        w_ctrl = ALU_AND;
                        w_ill  = 1'b0;
                    end
                    {F7_BASE, 3'b100}: begin
                        w_ctrl = ALU_XOR;
                        w_ill  = 1'b0;
                    end
                    {F7_BASE, 3'b001}: begin
                        w_ctrl = ALU_SL;
                        w_ill  = 1'b0;
                    end
                    {F7_ALT, 3'b101}: begin
                        w_ctrl = ALU_SR;
                        w_ill  = 1'b0;
                    end
                    default: ;
                endcase
            end
            OP_I: begin
                unique case (w_f3)
                    3'b000: begin
                        w_ctrl = ALU_ADD;
                        w_ill  = 1'b0;
                        w_src  = SRC_SIMM;
                    end
                    3'b111: begin
                        w_ctrl = ALU_AND;
                        w_ill  = 1'b0;
                        w_src  = SRC_SIMM;
                    end
                    3'b100: begin
                        w_ctrl = ALU_XOR;
                        w_ill  = 1'b0;
                        w_src  = SRC_SIMM;
                    end
                    3'b001: begin
                        if (w_f7 == F7_BASE) begin
                            w_ctrl = ALU_SL;
                            w_ill  = 1'b0;
                            w_src  = SRC_SHAMT;
                        end
                    end
                    3'b101: begin
                        // Only the arithmetic right shift encoding is legal
                        if (w_f7 == F7_ALT) begin
                            w_ctrl = ALU_SR;
                            w_ill  = 1'b0;
                            w_src  = SRC_SHAMT;
                        end
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

`ifdef ID_EX_FORWARD_EN
    // The held instruction's result is only on alu_result_i in the
    // cycle it is consumed, so forwarding is gated by the drain.
    logic w_fwd;
    assign w_fwd  = w_drain && r_we && (r_rd != 5'd0);
    assign w_op_a = (w_fwd && (instr_i[19:15] == r_rd))
                  ? alu_result_i : rs1_data_i;
    assign w_rs2  = (w_fwd && w_is_r && (instr_i[24:20] == r_rd))
                  ? alu_result_i : rs2_data_i;
`else
    logic w_unused_fwd;
    assign w_unused_fwd = ^{instr_i[19:15], w_is_r};
    assign w_op_a = rs1_data_i;
    assign w_rs2  = rs2_data_i;
`endif

    assign w_simm  = {{(DW-12){instr_i[31]}}, instr_i[31:20]};
    assign w_shamt = {{(DW-5){1'b0}}, instr_i[24:20]};

    always_comb begin
        w_op_b = w_rs2;
        unique case (w_src)
            SRC_SIMM:  w_op_b = w_simm;
            SRC_SHAMT: w_op_b = w_shamt;
            default:   w_op_b = w_rs2;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_ctrl  <= BUBBLE_CTRL;
            r_rs1   <= '0;
            r_mux   <= '0;
            r_rd    <= 5'd0;
            r_we    <= 1'b0;
            r_ill   <= 1'b0;
        end else if (flush_i) begin
            r_valid <= 1'b0;
            r_ctrl  <= BUBBLE_CTRL;
            r_we    <= 1'b0;
            r_ill   <= 1'b0;
        end else if (w_xfer) begin
            r_valid <= 1'b1;
            r_ctrl  <= w_ctrl;
            r_rs1   <= w_op_a;
            r_mux   <= w_op_b;
            r_rd    <= instr_i[11:7];
            r_we    <= !w_ill;
            r_ill   <= w_ill;
        end else if (w_drain) begin
            // Emptying: present a bubble so the ALU sees no write
            r_valid <= 1'b0;
            r_ctrl  <= BUBBLE_CTRL;
            r_we    <= 1'b0;
            r_ill   <= 1'b0;
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = r_valid;
    assign rs1_data   = r_rs1;
    assign mux_o      = r_mux;
    assign AluControl = r_ctrl;
    assign rd_addr    = r_rd;
    assign reg_write  = r_we;
    assign illegal    = r_ill;

endmodule
